// File: rtl/cfg_chain_loader.sv
// Streams DATA_W-bit words into NUM_CHAINS parallel configuration shift chains, then pulses set.
// Optional readback verify (compare chain tails while re-shifting) enabled by CFG_CHAIN_LOADER_READBACK_EN.
module cfg_chain_loader #(
    parameter int NUM_CHAINS = 4,
    parameter int DATA_W     = 32,
    parameter int CHAIN_LEN  = 256,
    parameter int SET_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cen,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  verify,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_W-1:0]     s_data,
    output logic [NUM_CHAINS-1:0] shift_out,
    output logic                  shift_en,
    output logic                  set_out,
    output logic                  busy,
    output logic                  done,
    input  logic [NUM_CHAINS-1:0] chain_tail_in,
    output logic                  mismatch,
    output logic [15:0]           mismatch_cnt
);
    localparam int SLICE = DATA_W / NUM_CHAINS;
    localparam int KW    = (SLICE > 1) ? $clog2(SLICE) : 1;
    localparam int CW    = $clog2(CHAIN_LEN + 1);
    localparam int SW    = (SET_CYCLES > 1) ? $clog2(SET_CYCLES) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SHIFT,
        ST_SET,
        ST_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic [KW-1:0]     k_q, k_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [SW-1:0]     set_cnt_q, set_cnt_d;
    logic              mode_q, mode_d;

    logic                  verify_eff;
    logic [CW-1:0]         cnt_inc;
    logic                  last_slice;
    logic                  chain_full;
    logic                  live;
    logic                  hs;
    logic [NUM_CHAINS-1:0] slices [SLICE];

    // Slice k carries bit c of every chain at word bit c + NUM_CHAINS*k.
    for (genvar gi = 0; gi < SLICE; gi++) begin : g_slice
        assign slices[gi] = word_q[gi*NUM_CHAINS +: NUM_CHAINS];
    end

    assign cnt_inc    = cnt_q + CW'(1);
    assign last_slice = (k_q == KW'(SLICE - 1));
    assign chain_full = (cnt_inc == CW'(CHAIN_LEN));
    assign live       = cen & ~abort;

    assign shift_en  = live & (state_q == ST_SHIFT);
    assign shift_out = shift_en ? slices[k_q] : '0;
    // Mid-shift ready only on the final slice, so the next word lands with no bubble.
    assign s_ready   = live & ((state_q == ST_FETCH) |
                               ((state_q == ST_SHIFT) & last_slice & ~chain_full));
    assign set_out   = ~abort & (state_q == ST_SET);
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign hs        = s_valid & s_ready;

    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        k_d       = k_q;
        cnt_d     = cnt_q;
        set_cnt_d = set_cnt_q;
        mode_d    = mode_q;
        if (cen) begin
            if (abort) begin
                state_d = ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start) begin
                            mode_d    = verify_eff;
                            cnt_d     = '0;
                            k_d       = '0;
                            set_cnt_d = '0;
                            state_d   = ST_FETCH;
                        end
                    end
                    ST_FETCH: begin
                        if (hs) begin
                            word_d  = s_data;
                            k_d     = '0;
                            state_d = ST_SHIFT;
                        end
                    end
                    ST_SHIFT: begin
                        cnt_d = cnt_inc;
                        k_d   = last_slice ? '0 : k_q + KW'(1);
                        if (chain_full) begin
                            set_cnt_d = '0;
                            state_d   = mode_q ? ST_DONE : ST_SET;
                        end else if (last_slice) begin
                            if (hs) begin
                                word_d = s_data;
                            end else begin
                                state_d = ST_FETCH;
                            end
                        end
                    end
                    ST_SET: begin
                        if (set_cnt_q == SW'(SET_CYCLES - 1)) begin
                            state_d = ST_DONE;
                        end else begin
                            set_cnt_d = set_cnt_q + SW'(1);
                        end
                    end
                    ST_DONE: state_d = ST_IDLE;
                    default: state_d = ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            word_q    <= '0;
            k_q       <= '0;
            cnt_q     <= '0;
            set_cnt_q <= '0;
            mode_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            k_q       <= k_d;
            cnt_q     <= cnt_d;
            set_cnt_q <= set_cnt_d;
            mode_q    <= mode_d;
        end
    end

`ifdef CFG_CHAIN_LOADER_READBACK_EN
    logic                  mismatch_q, mismatch_d;
    logic [15:0]           mm_cnt_q, mm_cnt_d;
    logic [NUM_CHAINS-1:0] diff;
    logic [16:0]           pop;
    logic [16:0]           mm_sum;
    logic                  start_accept;

    assign verify_eff   = verify;
    assign start_accept = live & start & (state_q == ST_IDLE);
    // FIFO chains: the tail bit now is the bit that entered at this same shift index last pass.
    assign diff         = chain_tail_in ^ shift_out;

    always_comb begin
        pop = '0;
        for (int i = 0; i < NUM_CHAINS; i++) begin
            pop = pop + 17'(diff[i]);
        end
        mm_sum     = {1'b0, mm_cnt_q} + pop;
        mismatch_d = mismatch_q;
        mm_cnt_d   = mm_cnt_q;
        if (start_accept) begin
            mismatch_d = 1'b0;
            mm_cnt_d   = '0;
        end else if (shift_en && mode_q) begin
            mismatch_d = mismatch_q | (|diff);
            mm_cnt_d   = mm_sum[16] ? 16'hFFFF : mm_sum[15:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mismatch_q <= 1'b0;
            mm_cnt_q   <= '0;
        end else begin
            mismatch_q <= mismatch_d;
            mm_cnt_q   <= mm_cnt_d;
        end
    end

    assign mismatch     = mismatch_q;
    assign mismatch_cnt = mm_cnt_q;
`else
    logic unused_readback;

    assign verify_eff      = 1'b0;
    assign unused_readback = ^{verify, chain_tail_in};
    assign mismatch        = 1'b0;
    assign mismatch_cnt    = '0;
`endif

endmodule
